mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N, default 2048: memory size in bytes; AW = $clog2(N) is the address width.
REQ-002 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 i_reset  in  1  reset, synchronous, active-high.
REQ-004 i_ifu_req  in  1 / i_ifu_addr  in  AW: fetch-port request (read-only, full 4-byte read).
REQ-005 o_ifu_ready  out  1: fetch request accepted this cycle.
REQ-006 o_ifu_rvalid  out  1 / o_ifu_rdata  out  32 / i_ifu_rready  in  1: fetch response handshake.
REQ-007 i_lsu_req  in  1 / i_lsu_addr  in  AW / i_lsu_wren  in  1 / i_lsu_bmask  in  4 / i_lsu_wdata  in  32: load/store-port request.
REQ-008 o_lsu_ready  out  1: load/store request accepted this cycle.
REQ-009 o_lsu_rvalid  out  1 / o_lsu_rdata  out  32 / i_lsu_rready  in  1: load/store response handshake.
REQ-010 o_mem_addr  out  AW / o_mem_bmask  out  4 / o_mem_wdata  out  32 / o_mem_wren  out  1: drive to the byte memory port.
REQ-011 i_mem_rdata  in  32: combinational read data from the memory.

Function
REQ-012 Each port SHALL own a one-entry response slot with states EMPTY and FULL; rvalid = (slot == FULL).
REQ-013 A port SHALL be eligible when req=1 and its slot is EMPTY, or FULL with rready=1 in the same cycle.
REQ-014 Grant SHALL be combinational: at most one of o_ifu_ready/o_lsu_ready is high, and ready=1 only for the granted eligible port.
REQ-015 When both ports are eligible, the grant SHALL go to the port not granted most recently (round-robin pointer); the pointer SHALL update only on a grant.
REQ-016 When only one port is eligible, that port SHALL be granted regardless of the pointer.
REQ-017 Memory outputs SHALL mux the granted port's request in the same cycle.
REQ-018 o_mem_wren SHALL equal i_lsu_wren only on an LSU grant and SHALL be 0 otherwise.
REQ-019 An IFU grant SHALL drive bmask 4'b0000.
REQ-020 With no grant, all o_mem_* SHALL be 0.
REQ-021 Latency: a request granted in cycle T SHALL load its slot and assert rvalid in cycle T+1.
REQ-022 Read response: rdata = i_mem_rdata sampled in cycle T.
REQ-023 Write response (LSU wren=1): rdata = 32'h0; the memory write completes at the edge ending T.
REQ-024 A slot SHALL stay FULL with stable rdata until rvalid&&rready.
REQ-025 If FULL, rready=1 and a new grant occur in the same cycle, the slot SHALL reload with the new response (back-to-back, one access per cycle per port).
REQ-026 An LSU write with bmask 4'b0000 SHALL be accepted and acknowledged with no byte changed.
REQ-027 Out-of-range and unaligned addresses SHALL be forwarded unmodified; the memory's out-of-range zero return is passed through.
REQ-028 Each port's requests SHALL complete in order, and accesses from both ports SHALL be serialised in grant order.

Reset
REQ-029 While i_reset=1 at a clock edge, both slots SHALL go EMPTY, rdata SHALL be 0, and the round-robin pointer SHALL favour IFU.
REQ-030 During i_reset=1, both ready outputs and o_mem_wren SHALL be forced to 0 combinationally.
REQ-031 Reset mid-operation SHALL drop pending responses, so rvalid is 0 in the cycle after reset.

Structure
REQ-032 A shared package SHALL hold the port-index enum (PORT_IFU=0, PORT_LSU=1) and the slot-state enum (EMPTY, FULL).
REQ-033 The response slot SHALL be one sub-module, rsp_slot, instantiated twice; arbitration and the mux SHALL stay in mem_arbiter.

Verification
REQ-034 Reset, then IFU-only read of addr 0x010 (memory 0x11223344) -> ready in T, rvalid in T+1 with rdata 0x11223344.
REQ-035 Both ports request every cycle, rready=1 -> grants alternate IFU, LSU, IFU, LSU…, with no port starved more than 1 cycle.
REQ-036 LSU write addr 0x004, bmask 4'b0011, wdata 0xAABBCCDD, then IFU read 0x004 (prior 0) -> write ack rdata 0, then read returns 0x0000CCDD.
REQ-037 IFU rready held 0 for 3 cycles with a pending response -> rvalid and rdata stable, IFU not granted, LSU granted each cycle it requests.
REQ-038 Reset asserted one cycle after a grant -> rvalid 0 after reset, no write on o_mem_wren, IFU wins the first contended cycle.
REQ-039 LSU read at addr N-2 -> rdata upper two bytes 0x00, and the response completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: port identifiers and
// response-slot occupancy states.
package mem_arbiter_pkg;

  typedef enum logic {
    PORT_IFU = 1'b0,
    PORT_LSU = 1'b1
  } port_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bus of the fetch and load/store ports plus the byte-memory
// port; the arbiter takes the slave view, the requesters/memory the master view.
interface mem_arbiter_if #(
  parameter int AW = 11
);
  logic          i_ifu_req;
  logic [AW-1:0] i_ifu_addr;
  logic          o_ifu_ready;
  logic          o_ifu_rvalid;
  logic [31:0]   o_ifu_rdata;
  logic          i_ifu_rready;

  logic          i_lsu_req;
  logic [AW-1:0] i_lsu_addr;
  logic          i_lsu_wren;
  logic [3:0]    i_lsu_bmask;
  logic [31:0]   i_lsu_wdata;
  logic          o_lsu_ready;
  logic          o_lsu_rvalid;
  logic [31:0]   o_lsu_rdata;
  logic          i_lsu_rready;

  logic [AW-1:0] o_mem_addr;
  logic [3:0]    o_mem_bmask;
  logic [31:0]   o_mem_wdata;
  logic          o_mem_wren;
  logic [31:0]   i_mem_rdata;

  modport slave (
    input  i_ifu_req, i_ifu_addr, i_ifu_rready,
    output o_ifu_ready, o_ifu_rvalid, o_ifu_rdata,
    input  i_lsu_req, i_lsu_addr, i_lsu_wren, i_lsu_bmask, i_lsu_wdata, i_lsu_rready,
    output o_lsu_ready, o_lsu_rvalid, o_lsu_rdata,
    output o_mem_addr, o_mem_bmask, o_mem_wdata, o_mem_wren,
    input  i_mem_rdata
  );

  modport master (
    output i_ifu_req, i_ifu_addr, i_ifu_rready,
    input  o_ifu_ready, o_ifu_rvalid, o_ifu_rdata,
    output i_lsu_req, i_lsu_addr, i_lsu_wren, i_lsu_bmask, i_lsu_wdata, i_lsu_rready,
    input  o_lsu_ready, o_lsu_rvalid, o_lsu_rdata,
    input  o_mem_addr, o_mem_bmask, o_mem_wdata, o_mem_wren,
    output i_mem_rdata
  );
endinterface

// File: rtl/mem_arbiter_rsp_slot.sv
// One-entry response holding register for a single requester port; reports
// whether it can take a new response this cycle.
module rsp_slot
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        rready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        free
);

  slot_state_e state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  // A load in the same cycle as a drain wins, giving back-to-back responses.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    if (state_q == FULL && rready) begin
      state_d = EMPTY;
    end
    if (load) begin
      state_d = FULL;
      rdata_d = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  assign rvalid = (state_q == FULL);
  assign rdata  = rdata_q;
  assign free   = (state_q == EMPTY) || rready;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one combinational byte-memory port between the
// fetch (read-only) and load/store requesters, one access per cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N = 2048
) (
  input  logic          i_clk,
  input  logic          i_reset,
  mem_arbiter_if.slave  bus
);

  localparam int AW = $clog2(N);

  logic          ifu_free, lsu_free;
  logic          ifu_elig, lsu_elig;
  logic          gnt_ifu, gnt_lsu;
  port_e         prio_q, prio_d;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_bmask;
  logic [31:0]   mem_wdata;
  logic          mem_wren;
  logic [31:0]   lsu_load_data;

  // prio_q names the port that wins the next contended cycle.
  always_comb begin
    ifu_elig = bus.i_ifu_req && ifu_free;
    lsu_elig = bus.i_lsu_req && lsu_free;
    gnt_ifu  = 1'b0;
    gnt_lsu  = 1'b0;
    if (!i_reset) begin
      if (ifu_elig && lsu_elig) begin
        gnt_ifu = (prio_q == PORT_IFU);
        gnt_lsu = (prio_q == PORT_LSU);
      end else begin
        gnt_ifu = ifu_elig;
        gnt_lsu = lsu_elig;
      end
    end
    prio_d = prio_q;
    if (gnt_ifu) begin
      prio_d = PORT_LSU;
    end else if (gnt_lsu) begin
      prio_d = PORT_IFU;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prio_q <= PORT_IFU;
    end else begin
      prio_q <= prio_d;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_bmask = 4'b0000;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    if (gnt_ifu) begin
      mem_addr = bus.i_ifu_addr;
    end else if (gnt_lsu) begin
      mem_addr  = bus.i_lsu_addr;
      mem_bmask = bus.i_lsu_bmask;
      mem_wdata = bus.i_lsu_wdata;
      mem_wren  = bus.i_lsu_wren;
    end
  end

  assign lsu_load_data   = bus.i_lsu_wren ? 32'h0 : bus.i_mem_rdata;

  assign bus.o_ifu_ready = gnt_ifu;
  assign bus.o_lsu_ready = gnt_lsu;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_bmask = mem_bmask;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_mem_wren  = mem_wren;

  rsp_slot u_ifu_slot (
    .clk       (i_clk),
    .rst       (i_reset),
    .load      (gnt_ifu),
    .load_data (bus.i_mem_rdata),
    .rready    (bus.i_ifu_rready),
    .rvalid    (bus.o_ifu_rvalid),
    .rdata     (bus.o_ifu_rdata),
    .free      (ifu_free)
  );

  rsp_slot u_lsu_slot (
    .clk       (i_clk),
    .rst       (i_reset),
    .load      (gnt_lsu),
    .load_data (lsu_load_data),
    .rready    (bus.i_lsu_rready),
    .rvalid    (bus.o_lsu_rvalid),
    .rdata     (bus.o_lsu_rdata),
    .free      (lsu_free)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte memory environment, queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_mem_arbiter;
  localparam int N  = 2048;
  localparam int AW = $clog2(N);

  logic clk;
  logic rst;
  logic copy_en;

  mem_arbiter_if #(.AW(AW)) bus ();

  mem_arbiter #(.N(N)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment memory (what the DUT actually talks to)
  logic [7:0] env_mem [N];
  // Reference model's own view of memory contents
  logic [7:0] ref_mem [N];

  always_comb begin
    bus.i_mem_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = int'(bus.o_mem_addr) + k;
      if (idx < N) bus.i_mem_rdata[8*k +: 8] = env_mem[idx];
    end
  end

  always @(posedge clk) begin
    if (copy_en) begin
      for (int i = 0; i < N; i++) env_mem[i] <= ref_mem[i];
    end else if (bus.o_mem_wren) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = int'(bus.o_mem_addr) + k;
        if (bus.o_mem_bmask[k] && idx < N) env_mem[idx] <= bus.o_mem_wdata[8*k +: 8];
      end
    end
  end

  // Reference model state: pending responses per port, most recently granted port
  logic [31:0] q_ifu [$];
  logic [31:0] q_lsu [$];
  int          last_gnt;   // 0 = IFU, 1 = LSU
  int          n_cmp;
  int          n_mis;

  function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = int'(a) + k;
      if (idx < N) w[8*k +: 8] = ref_mem[idx];
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ireq, input logic [AW-1:0] iaddr, input logic irr,
                       input logic lreq, input logic [AW-1:0] laddr, input logic lwren,
                       input logic [3:0] lbm, input logic [31:0] lwd, input logic lrr);
    bus.i_ifu_req    = ireq;
    bus.i_ifu_addr   = iaddr;
    bus.i_ifu_rready = irr;
    bus.i_lsu_req    = lreq;
    bus.i_lsu_addr   = laddr;
    bus.i_lsu_wren   = lwren;
    bus.i_lsu_bmask  = lbm;
    bus.i_lsu_wdata  = lwd;
    bus.i_lsu_rready = lrr;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 4'h0, 32'h0, 1'b1);
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model.
  task automatic cycle();
    int          g;   // 0 none, 1 IFU, 2 LSU
    logic        ei, el;
    logic [31:0] ea, eb, ew, ewr;
    @(negedge clk);
    ei = !rst && bus.i_ifu_req && (q_ifu.size() == 0 || bus.i_ifu_rready);
    el = !rst && bus.i_lsu_req && (q_lsu.size() == 0 || bus.i_lsu_rready);
    if (ei && el)  g = (last_gnt == 0) ? 2 : 1;
    else if (ei)   g = 1;
    else if (el)   g = 2;
    else           g = 0;
    ea = '0; eb = '0; ew = '0; ewr = '0;
    if (g == 1) begin
      ea = 32'(bus.i_ifu_addr);
    end else if (g == 2) begin
      ea  = 32'(bus.i_lsu_addr);
      eb  = 32'(bus.i_lsu_bmask);
      ew  = bus.i_lsu_wdata;
      ewr = 32'(bus.i_lsu_wren);
    end
    chk("ifu_ready", 32'(bus.o_ifu_ready), 32'(g == 1));
    chk("lsu_ready", 32'(bus.o_lsu_ready), 32'(g == 2));
    chk("mem_addr",  32'(bus.o_mem_addr), ea);
    chk("mem_bmask", 32'(bus.o_mem_bmask), eb);
    chk("mem_wren",  32'(bus.o_mem_wren), ewr);
    if (g != 1) chk("mem_wdata", bus.o_mem_wdata, ew);
    chk("ifu_rvalid", 32'(bus.o_ifu_rvalid), 32'(q_ifu.size() != 0));
    chk("lsu_rvalid", 32'(bus.o_lsu_rvalid), 32'(q_lsu.size() != 0));
    if (q_ifu.size() != 0) chk("ifu_rdata", bus.o_ifu_rdata, q_ifu[0]);
    if (q_lsu.size() != 0) chk("lsu_rdata", bus.o_lsu_rdata, q_lsu[0]);

    if (rst) begin
      q_ifu.delete();
      q_lsu.delete();
      last_gnt = 1;
    end else begin
      if (q_ifu.size() != 0 && bus.i_ifu_rready) void'(q_ifu.pop_front());
      if (q_lsu.size() != 0 && bus.i_lsu_rready) void'(q_lsu.pop_front());
      if (g == 1) begin
        q_ifu.push_back(ref_rd(bus.i_ifu_addr));
        last_gnt = 0;
      end else if (g == 2) begin
        if (bus.i_lsu_wren) begin
          q_lsu.push_back(32'h0);
          for (int k = 0; k < 4; k++) begin
            int idx;
            idx = int'(bus.i_lsu_addr) + k;
            if (bus.i_lsu_bmask[k] && idx < N) ref_mem[idx] = bus.i_lsu_wdata[8*k +: 8];
          end
        end else begin
          q_lsu.push_back(ref_rd(bus.i_lsu_addr));
        end
        last_gnt = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] hold;
    logic        prev;
    n_cmp    = 0;
    n_mis    = 0;
    last_gnt = 1;
    for (int i = 0; i < N; i++) ref_mem[i] = 8'($urandom);
    {ref_mem[16'h13], ref_mem[16'h12], ref_mem[16'h11], ref_mem[16'h10]} = 32'h11223344;
    {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]} = 32'h0;

    // Reset with both ports clamouring, including a write
    rst     = 1'b1;
    copy_en = 1'b1;
    drive(1'b1, 11'h010, 1'b1, 1'b1, 11'h020, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1);
    @(posedge clk);
    #1;
    copy_en = 1'b0;
    chk("rst_wren", 32'(bus.o_mem_wren), 32'h0);
    cycle();
    cycle();
    rst = 1'b0;
    idle();
    #1;
    chk("rst_ifu_rvalid", 32'(bus.o_ifu_rvalid), 32'h0);
    chk("rst_lsu_rvalid", 32'(bus.o_lsu_rvalid), 32'h0);
    chk("rst_ifu_rdata", bus.o_ifu_rdata, 32'h0);
    chk("rst_lsu_rdata", bus.o_lsu_rdata, 32'h0);

    // IFU-only read
    drive(1'b1, 11'h010, 1'b1, 1'b0, '0, 1'b0, 4'h0, 32'h0, 1'b1);
    #1;
    chk("t34_ready", 32'(bus.o_ifu_ready), 32'h1);
    cycle();
    chk("t34_rvalid", 32'(bus.o_ifu_rvalid), 32'h1);
    chk("t34_rdata", bus.o_ifu_rdata, 32'h11223344);
    idle();
    cycle();

    // Continuous contention alternates grants
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, AW'($urandom), 1'b1, 1'b1, AW'($urandom), 1'b0, 4'hF, 32'h0, 1'b1);
      #1;
      chk("t35_one_grant", 32'(bus.o_ifu_ready) + 32'(bus.o_lsu_ready), 32'h1);
      if (i > 0) chk("t35_alternate", 32'(bus.o_ifu_ready), 32'(!prev));
      prev = bus.o_ifu_ready;
      cycle();
    end
    idle();
    cycle();

    // Partial write then read back
    drive(1'b0, '0, 1'b1, 1'b1, 11'h004, 1'b1, 4'b0011, 32'hAABBCCDD, 1'b1);
    cycle();
    chk("t36_wr_rvalid", 32'(bus.o_lsu_rvalid), 32'h1);
    chk("t36_wr_rdata", bus.o_lsu_rdata, 32'h0);
    drive(1'b1, 11'h004, 1'b1, 1'b0, '0, 1'b0, 4'h0, 32'h0, 1'b1);
    cycle();
    chk("t36_rd_rdata", bus.o_ifu_rdata, 32'h0000CCDD);
    idle();
    cycle();

    // IFU back-pressure: held response, LSU keeps flowing
    drive(1'b1, 11'h010, 1'b0, 1'b0, '0, 1'b0, 4'h0, 32'h0, 1'b1);
    cycle();
    hold = bus.o_ifu_rdata;
    chk("t37_first", hold, 32'h11223344);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 11'h020, 1'b0, 1'b1, AW'($urandom), 1'b0, 4'hF, 32'h0, 1'b1);
      #1;
      chk("t37_ifu_ready", 32'(bus.o_ifu_ready), 32'h0);
      chk("t37_lsu_ready", 32'(bus.o_lsu_ready), 32'h1);
      cycle();
      chk("t37_rvalid", 32'(bus.o_ifu_rvalid), 32'h1);
      chk("t37_stable", bus.o_ifu_rdata, hold);
    end
    idle();
    cycle();

    // Reset one cycle after a grant
    drive(1'b0, '0, 1'b1, 1'b1, 11'h040, 1'b1, 4'hF, $urandom, 1'b0);
    #1;
    chk("t38_grant", 32'(bus.o_lsu_ready), 32'h1);
    cycle();
    rst = 1'b1;
    drive(1'b1, 11'h010, 1'b1, 1'b1, 11'h044, 1'b1, 4'hF, $urandom, 1'b1);
    #1;
    chk("t38_wren", 32'(bus.o_mem_wren), 32'h0);
    chk("t38_lsu_ready", 32'(bus.o_lsu_ready), 32'h0);
    chk("t38_ifu_ready", 32'(bus.o_ifu_ready), 32'h0);
    cycle();
    rst = 1'b0;
    idle();
    #1;
    chk("t38_ifu_rvalid", 32'(bus.o_ifu_rvalid), 32'h0);
    chk("t38_lsu_rvalid", 32'(bus.o_lsu_rvalid), 32'h0);
    drive(1'b1, 11'h010, 1'b1, 1'b1, 11'h040, 1'b0, 4'hF, 32'h0, 1'b1);
    #1;
    chk("t38_ifu_first", 32'(bus.o_ifu_ready), 32'h1);
    cycle();
    idle();
    cycle();
    cycle();

    // Read straddling the top of memory
    drive(1'b0, '0, 1'b1, 1'b1, AW'(N - 2), 1'b0, 4'hF, 32'h0, 1'b0);
    cycle();
    chk("t39_rvalid", 32'(bus.o_lsu_rvalid), 32'h1);
    chk("t39_upper", 32'(bus.o_lsu_rdata[31:16]), 32'h0);
    idle();
    cycle();
    chk("t39_done", 32'(bus.o_lsu_rvalid), 32'h0);

    // Randomized traffic, occasional reset
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive(($urandom_range(0, 3) != 0), AW'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), AW'($urandom), 1'($urandom_range(0, 1)),
            4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
